// File: rtl/dma_seq_fsm.sv
// Layer-by-layer DMA sequencer: walks DIMS/WEIGHTS/BIASES for every layer, then the image set,
// splitting each region into bounded bursts issued over a req/ack/done handshake.
module dma_seq_fsm #(
  parameter int ADDR_W     = 32,
  parameter int LEN_W      = 16,
  parameter int NUM_LAYERS = 4,
  parameter int MAX_BURST  = 16,
  localparam int LIDX_W    = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] cfg_dim_base,
  input  logic [ADDR_W-1:0] cfg_wt_base,
  input  logic [ADDR_W-1:0] cfg_bias_base,
  input  logic [ADDR_W-1:0] cfg_img_base,
  input  logic [LEN_W-1:0]  cfg_dim_len,
  input  logic [LEN_W-1:0]  cfg_wt_len,
  input  logic [LEN_W-1:0]  cfg_bias_len,
  input  logic [LEN_W-1:0]  cfg_img_len,
  input  logic [LEN_W-1:0]  cfg_num_images,
  output logic              dma_req,
  output logic [ADDR_W-1:0] dma_addr,
  output logic [LEN_W-1:0]  dma_len,
  output logic [1:0]        dma_sel,
  input  logic              dma_ack,
  input  logic              dma_done,
  output logic              busy,
  output logic [LIDX_W-1:0] layer_idx,
  output logic              done,
  output logic              aborted
);

  typedef enum logic [2:0] {IDLE, DIMS, WEIGHTS, BIASES, IMAGES, WAIT, FIN} stateT;

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BURST);

  stateT             state, retState, curPhase, nxtPhase;
  logic [ADDR_W-1:0] ptr [4];
  logic [LEN_W-1:0]  dimLen, wtLen, biasLen, imgLen, numImg;
  logic [LEN_W-1:0]  rem, imgCnt, nxtRem, burstLen;
  logic              abortPend, phaseDone, lastLayer, advance, xferState;
  logic [1:0]        curSel;

  always_comb begin
    xferState = (state == DIMS) || (state == WEIGHTS) || (state == BIASES) || (state == IMAGES);
    curPhase  = (state == WAIT) ? retState : state;
    lastLayer = (layer_idx == LIDX_W'(NUM_LAYERS - 1));
    // In IMAGES, rem is reloaded per image, so the image counter decides completion.
    phaseDone = (rem == '0) || ((curPhase == IMAGES) && (imgCnt == '0));
    burstLen  = (rem > MAX_LEN) ? MAX_LEN : rem;
    curSel    = 2'd0;
    case (state)
      WEIGHTS: curSel = 2'd1;
      BIASES:  curSel = 2'd2;
      IMAGES:  curSel = 2'd3;
      default: curSel = 2'd0;
    endcase
    nxtPhase = FIN;
    nxtRem   = '0;
    case (curPhase)
      DIMS:    begin nxtPhase = WEIGHTS; nxtRem = wtLen;   end
      WEIGHTS: begin nxtPhase = BIASES;  nxtRem = biasLen; end
      BIASES: begin
        if (lastLayer) begin nxtPhase = IMAGES; nxtRem = imgLen; end
        else           begin nxtPhase = DIMS;   nxtRem = dimLen; end
      end
      default: begin nxtPhase = FIN; nxtRem = '0; end
    endcase
    advance = (xferState && !dma_req && !abort && phaseDone) ||
              ((state == WAIT) && dma_done && !abortPend && !abort && phaseDone);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      retState  <= IDLE;
      dma_req   <= 1'b0;
      dma_addr  <= '0;
      dma_len   <= '0;
      dma_sel   <= 2'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
      layer_idx <= '0;
      abortPend <= 1'b0;
      rem       <= '0;
      imgCnt    <= '0;
      dimLen    <= '0;
      wtLen     <= '0;
      biasLen   <= '0;
      imgLen    <= '0;
      numImg    <= '0;
      for (int i = 0; i < 4; i++) ptr[i] <= '0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dimLen    <= cfg_dim_len;
            wtLen     <= cfg_wt_len;
            biasLen   <= cfg_bias_len;
            imgLen    <= cfg_img_len;
            numImg    <= cfg_num_images;
            ptr[0]    <= cfg_dim_base;
            ptr[1]    <= cfg_wt_base;
            ptr[2]    <= cfg_bias_base;
            ptr[3]    <= cfg_img_base;
            rem       <= cfg_dim_len;
            imgCnt    <= '0;
            layer_idx <= '0;
            abortPend <= 1'b0;
            busy      <= 1'b1;
            retState  <= DIMS;
            state     <= DIMS;
          end
        end
        DIMS, WEIGHTS, BIASES, IMAGES: begin
          if (dma_req && dma_ack) begin
            dma_req      <= 1'b0;
            ptr[dma_sel] <= ptr[dma_sel] + ADDR_W'({dma_len, 2'b00});
            if ((state == IMAGES) && (rem == dma_len)) begin
              imgCnt <= imgCnt - LEN_W'(1);
              rem    <= imgLen;
            end else begin
              rem <= rem - dma_len;
            end
            abortPend <= abort;
            retState  <= state;
            state     <= WAIT;
          end else if (abort) begin
            dma_req <= 1'b0;
            busy    <= 1'b0;
            aborted <= 1'b1;
            state   <= IDLE;
          end else if (!dma_req && !phaseDone) begin
            dma_req  <= 1'b1;
            dma_addr <= ptr[curSel];
            dma_len  <= burstLen;
            dma_sel  <= curSel;
          end
        end
        WAIT: begin
          if (abort) abortPend <= 1'b1;
          if (dma_done && (abortPend || abort)) begin
            abortPend <= 1'b0;
            busy      <= 1'b0;
            aborted   <= 1'b1;
            state     <= IDLE;
          end else if (dma_done && !phaseDone) begin
            state <= retState;
          end
        end
        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // Phase change; the layer counter steps only when BIASES rolls back to DIMS.
      if (advance) begin
        state  <= nxtPhase;
        rem    <= nxtRem;
        imgCnt <= numImg;
        if ((curPhase == BIASES) && !lastLayer) layer_idx <= layer_idx + LIDX_W'(1);
        if (nxtPhase == FIN) done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dma_seq_fsm.sv
// Directed bench for dma_seq_fsm: a scripted DMA responder logs every burst and compares it
// against hand-computed burst tables, handshake timing, abort and reset behaviour.
module tb_dma_seq_fsm;

  logic        clk = 1'b0;
  logic        rst_n, startA, startB, abort, dma_ack, dma_done, useB;
  logic [31:0] cfg_dim_base, cfg_wt_base, cfg_bias_base, cfg_img_base;
  logic [15:0] cfg_dim_len, cfg_wt_len, cfg_bias_len, cfg_img_len, cfg_num_images;

  logic        reqA, busyA, doneA, abortedA, reqB, busyB, doneB, abortedB;
  logic [31:0] addrA, addrB;
  logic [15:0] lenA, lenB;
  logic [1:0]  selA, selB;
  logic [0:0]  layerA, layerB;

  logic        reqS, busyS, doneS, abortedS;
  logic [31:0] addrS;
  logic [15:0] lenS;
  logic [1:0]  selS;
  logic [0:0]  layerS;

  int nChecks = 0;
  int nErrors = 0;
  int nDone, nAborted, doneCyc;
  logic [31:0] gotAddr[$], expAddr[$];
  int gotLen[$], gotSel[$], gotLayer[$], gotCyc[$], doneSet[$];
  int expLen[$], expSel[$], expLayer[$];

  always #5 clk = ~clk;

  dma_seq_fsm #(.ADDR_W(32), .LEN_W(16), .NUM_LAYERS(2), .MAX_BURST(16)) dutA (
    .clk(clk), .rst_n(rst_n), .start(startA), .abort(abort),
    .cfg_dim_base(cfg_dim_base), .cfg_wt_base(cfg_wt_base), .cfg_bias_base(cfg_bias_base),
    .cfg_img_base(cfg_img_base), .cfg_dim_len(cfg_dim_len), .cfg_wt_len(cfg_wt_len),
    .cfg_bias_len(cfg_bias_len), .cfg_img_len(cfg_img_len), .cfg_num_images(cfg_num_images),
    .dma_req(reqA), .dma_addr(addrA), .dma_len(lenA), .dma_sel(selA),
    .dma_ack(dma_ack), .dma_done(dma_done), .busy(busyA), .layer_idx(layerA),
    .done(doneA), .aborted(abortedA)
  );

  dma_seq_fsm #(.ADDR_W(32), .LEN_W(16), .NUM_LAYERS(2), .MAX_BURST(4)) dutB (
    .clk(clk), .rst_n(rst_n), .start(startB), .abort(abort),
    .cfg_dim_base(cfg_dim_base), .cfg_wt_base(cfg_wt_base), .cfg_bias_base(cfg_bias_base),
    .cfg_img_base(cfg_img_base), .cfg_dim_len(cfg_dim_len), .cfg_wt_len(cfg_wt_len),
    .cfg_bias_len(cfg_bias_len), .cfg_img_len(cfg_img_len), .cfg_num_images(cfg_num_images),
    .dma_req(reqB), .dma_addr(addrB), .dma_len(lenB), .dma_sel(selB),
    .dma_ack(dma_ack), .dma_done(dma_done), .busy(busyB), .layer_idx(layerB),
    .done(doneB), .aborted(abortedB)
  );

  assign reqS     = useB ? reqB     : reqA;
  assign addrS    = useB ? addrB    : addrA;
  assign lenS     = useB ? lenB     : lenA;
  assign selS     = useB ? selB     : selA;
  assign busyS    = useB ? busyB    : busyA;
  assign doneS    = useB ? doneB    : doneA;
  assign abortedS = useB ? abortedB : abortedA;
  assign layerS   = useB ? layerB   : layerA;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic setCfg(input logic [31:0] dimB, input logic [31:0] wtB, input logic [31:0] biasB,
                        input logic [31:0] imgB, input int dimL, input int wtL, input int biasL,
                        input int imgL, input int nImg);
    cfg_dim_base   = dimB;
    cfg_wt_base    = wtB;
    cfg_bias_base  = biasB;
    cfg_img_base   = imgB;
    cfg_dim_len    = 16'(dimL);
    cfg_wt_len     = 16'(wtL);
    cfg_bias_len   = 16'(biasL);
    cfg_img_len    = 16'(imgL);
    cfg_num_images = 16'(nImg);
  endtask

  task automatic clearExp();
    expAddr.delete(); expLen.delete(); expSel.delete(); expLayer.delete();
  endtask

  task automatic addExp(input int sel, input logic [31:0] addr, input int len, input int layer);
    expSel.push_back(sel); expAddr.push_back(addr); expLen.push_back(len); expLayer.push_back(layer);
  endtask

  task automatic addT1Bursts(input int count);
    logic [31:0] a [10];
    int s [10], l [10], y [10];
    a = '{32'h100, 32'h1000, 32'h1040, 32'h2000, 32'h108, 32'h1050, 32'h1090, 32'h2010, 32'h3000, 32'h3020};
    s = '{0, 1, 1, 2, 0, 1, 1, 2, 3, 3};
    l = '{2, 16, 4, 4, 2, 16, 4, 4, 8, 8};
    y = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 1};
    clearExp();
    for (int i = 0; i < count; i++) addExp(s[i], a[i], l[i], y[i]);
  endtask

  // mode: 0 plain, 1 abort in WAIT of burst modeBurst, 2 abort while its req is pending,
  // 3 reset in WAIT of burst modeBurst.
  task automatic runDma(input int ackDly, input int doneDly, input int mode, input int modeBurst,
                        input int maxCyc);
    int cyc = 0;
    int held = 0;
    int wcnt = 0;
    bit justAcked = 0;
    bit stop = 0;
    gotAddr.delete(); gotLen.delete(); gotSel.delete(); gotLayer.delete();
    gotCyc.delete(); doneSet.delete();
    nDone = 0; nAborted = 0; doneCyc = -1;
    @(negedge clk);
    if (useB) startB = 1'b1; else startA = 1'b1;
    while (!stop && cyc < maxCyc) begin
      @(negedge clk);
      cyc++;
      startA = 1'b0; startB = 1'b0; dma_ack = 1'b0; dma_done = 1'b0; abort = 1'b0;
      if (cyc == 1) begin
        cfg_dim_base = 32'h0BAD_0000; cfg_wt_base = 32'hDEAD_0000;
        cfg_wt_len = 16'd7; cfg_num_images = 16'd9;
      end
      if (justAcked) begin
        checkVal("reqDropAfterAck", reqS, 1'b0);
        justAcked = 0;
      end
      if (doneS) begin
        nDone++; doneCyc = cyc; stop = 1;
        checkVal("busyAtDone", busyS, 1'b1);
      end else if (abortedS) begin
        nAborted++; stop = 1;
        checkVal("reqAtAbort", reqS, 1'b0);
        checkVal("busyAtAbort", busyS, 1'b0);
      end else if (wcnt > 0) begin
        if (wcnt == doneDly && gotAddr.size() - 1 == modeBurst) begin
          if (mode == 1) abort = 1'b1;
          if (mode == 3) begin rst_n = 1'b0; stop = 1; end
        end
        if (!stop) begin
          wcnt--;
          if (wcnt == 0) begin dma_done = 1'b1; doneSet.push_back(cyc); end
        end
      end else if (reqS) begin
        if (held == 0) begin
          gotAddr.push_back(addrS); gotLen.push_back(int'(lenS)); gotSel.push_back(int'(selS));
          gotLayer.push_back(int'(layerS)); gotCyc.push_back(cyc);
          $display("burst %0d sel=%0d addr=0x%08h len=%0d layer=%0d cyc=%0d",
                   gotAddr.size() - 1, selS, addrS, lenS, layerS, cyc);
          checkVal("busyDuringReq", busyS, 1'b1);
        end else begin
          checkVal("holdAddr", addrS, gotAddr[gotAddr.size() - 1]);
          checkVal("holdLen", lenS, gotLen[gotLen.size() - 1]);
          checkVal("holdSel", selS, gotSel[gotSel.size() - 1]);
        end
        held++;
        if (mode == 2 && gotAddr.size() - 1 == modeBurst) begin
          abort = 1'b1;
        end else if (held >= ackDly) begin
          dma_ack = 1'b1; held = 0; wcnt = doneDly; justAcked = 1;
        end
      end
    end
    checkVal("runEnded", stop, 1'b1);
  endtask

  task automatic compareBursts(input string name);
    checkVal($sformatf("%s_count", name), gotAddr.size(), expAddr.size());
    for (int i = 0; i < expAddr.size() && i < gotAddr.size(); i++) begin
      checkVal($sformatf("%s_b%0d_sel", name, i), gotSel[i], expSel[i]);
      checkVal($sformatf("%s_b%0d_addr", name, i), gotAddr[i], expAddr[i]);
      checkVal($sformatf("%s_b%0d_len", name, i), gotLen[i], expLen[i]);
      checkVal($sformatf("%s_b%0d_layer", name, i), gotLayer[i], expLayer[i]);
    end
  endtask

  task automatic checkGap(input string tag, input int burstIdx, input int doneIdx, input int gap);
    if (gotCyc.size() > burstIdx && doneSet.size() > doneIdx)
      checkVal(tag, gotCyc[burstIdx] - doneSet[doneIdx], gap);
    else
      checkVal({tag, "_missing"}, gotCyc.size(), burstIdx + 1);
  endtask

  task automatic checkFinGap(input string tag, input int doneIdx, input int gap);
    if (doneSet.size() > doneIdx) checkVal(tag, doneCyc - doneSet[doneIdx], gap);
    else checkVal({tag, "_missing"}, doneSet.size(), doneIdx + 1);
  endtask

  task automatic checkResetOutputs(input string name);
    checkVal({name, "_req"}, reqS, 1'b0);
    checkVal({name, "_addr"}, addrS, 32'h0);
    checkVal({name, "_len"}, lenS, 16'h0);
    checkVal({name, "_sel"}, selS, 2'd0);
    checkVal({name, "_busy"}, busyS, 1'b0);
    checkVal({name, "_done"}, doneS, 1'b0);
    checkVal({name, "_aborted"}, abortedS, 1'b0);
    checkVal({name, "_layer"}, layerS, 1'b0);
  endtask

  initial begin
    int reqSeen;
    rst_n = 1'b0; startA = 1'b0; startB = 1'b0; abort = 1'b0;
    dma_ack = 1'b0; dma_done = 1'b0; useB = 1'b0;
    setCfg(32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    checkResetOutputs("reset");
    rst_n = 1'b1;

    // Two-layer reference run with 1-cycle ack and done.
    setCfg(32'h100, 32'h1000, 32'h2000, 32'h3000, 2, 20, 4, 8, 2);
    addT1Bursts(10);
    runDma(1, 1, 0, -1, 500);
    compareBursts("t1");
    checkVal("t1_done", nDone, 1);
    checkVal("t1_aborted", nAborted, 0);
    checkGap("t1_wtGap", 1, 0, 2);
    checkFinGap("t1_finGap", 9, 1);
    @(negedge clk);
    checkVal("t1_idleBusy", busyS, 1'b0);

    // Zero weights and zero images: each empty phase costs one extra cycle.
    setCfg(32'h100, 32'h1000, 32'h2000, 32'h3000, 2, 0, 4, 8, 0);
    clearExp();
    addExp(0, 32'h100, 2, 0); addExp(2, 32'h2000, 4, 0);
    addExp(0, 32'h108, 2, 1); addExp(2, 32'h2010, 4, 1);
    runDma(1, 1, 0, -1, 500);
    compareBursts("t2");
    checkVal("t2_done", nDone, 1);
    checkGap("t2_wtSkipGap", 1, 0, 3);
    checkFinGap("t2_imgSkipGap", 3, 2);

    // Ack held off for 5 cycles per burst.
    setCfg(32'h100, 32'h1000, 32'h2000, 32'h3000, 2, 20, 4, 8, 2);
    addT1Bursts(10);
    runDma(5, 1, 0, -1, 1500);
    compareBursts("t3");
    checkVal("t3_done", nDone, 1);

    // Abort during WAIT of the second WEIGHTS burst.
    setCfg(32'h100, 32'h1000, 32'h2000, 32'h3000, 2, 20, 4, 8, 2);
    addT1Bursts(3);
    runDma(1, 3, 1, 2, 500);
    compareBursts("t4");
    checkVal("t4_done", nDone, 0);
    checkVal("t4_aborted", nAborted, 1);
    reqSeen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (reqS || doneS || abortedS) reqSeen++;
    end
    checkVal("t4_quietAfterAbort", reqSeen, 0);

    // Abort while a request is still waiting for ack.
    setCfg(32'h100, 32'h1000, 32'h2000, 32'h3000, 2, 20, 4, 8, 2);
    addT1Bursts(2);
    runDma(3, 1, 2, 1, 500);
    compareBursts("t4b");
    checkVal("t4b_done", nDone, 0);
    checkVal("t4b_aborted", nAborted, 1);

    // Image pointer wraps past the top of the address space (MAX_BURST=4 instance).
    useB = 1'b1;
    setCfg(32'h0, 32'h0, 32'h0, 32'hFFFF_FFF0, 0, 0, 0, 8, 1);
    clearExp();
    addExp(3, 32'hFFFF_FFF0, 4, 1); addExp(3, 32'h0000_0000, 4, 1);
    runDma(1, 1, 0, -1, 500);
    compareBursts("t5");
    checkVal("t5_done", nDone, 1);
    useB = 1'b0;

    // Reset in the middle of WAIT, then a clean run from a new configuration.
    setCfg(32'h100, 32'h1000, 32'h2000, 32'h3000, 2, 20, 4, 8, 2);
    runDma(1, 3, 3, 0, 500);
    @(negedge clk);
    checkResetOutputs("t6_reset");
    rst_n = 1'b1;
    setCfg(32'h500, 32'h6000, 32'h7000, 32'h4000, 3, 0, 0, 5, 1);
    clearExp();
    addExp(0, 32'h500, 3, 0); addExp(0, 32'h50C, 3, 1); addExp(3, 32'h4000, 5, 1);
    runDma(1, 1, 0, -1, 500);
    compareBursts("t6");
    checkVal("t6_done", nDone, 1);
    checkVal("t6_aborted", nAborted, 0);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
